// File: rtl/ow_pkg.sv
// Shared command bytes, FSM encodings and the Dallas/Maxim CRC-8 step used by
// the DS18B20 measurement sequencer.
package ow_pkg;

  localparam logic [7:0] OW_CMD_SKIP_ROM     = 8'hCC;
  localparam logic [7:0] OW_CMD_CONVERT_T    = 8'h44;
  localparam logic [7:0] OW_CMD_READ_SCRATCH = 8'hBE;
  localparam int         SCRATCH_BYTES       = 9;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_RST1   = 4'd1,
    ST_SKIP1  = 4'd2,
    ST_CONV   = 4'd3,
    ST_WAIT   = 4'd4,
    ST_RST2   = 4'd5,
    ST_SKIP2  = 4'd6,
    ST_RDCMD  = 4'd7,
    ST_RDBYTE = 4'd8,
    ST_CHECK  = 4'd9,
    ST_ERROR  = 4'd10
  } seq_state_t;

  typedef enum logic [1:0] {
    PH_ISSUE = 2'd0,
    PH_WHI   = 2'd1,
    PH_WLO   = 2'd2
  } cmd_phase_t;

  // One byte through x^8+x^5+x^4+1, LSB first (reflected polynomial 0x8C).
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] din);
    logic [7:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ din[i]) c = (c >> 1) ^ 8'h8C;
      else               c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/ds18b20_sequencer_if.sv
// Command/result bus between the DS18B20 sequencer (master) and the one_wire
// byte engine (slave).
interface ds18b20_sequencer_if;
  logic       ow_reset;
  logic       ow_write_byte;
  logic       ow_read_byte;
  logic [7:0] ow_in_byte;
  logic       ow_busy;
  logic       ow_presense;
  logic [7:0] ow_out_byte;

  modport master (
    output ow_reset, ow_write_byte, ow_read_byte, ow_in_byte,
    input  ow_busy, ow_presense, ow_out_byte
  );

  modport slave (
    input  ow_reset, ow_write_byte, ow_read_byte, ow_in_byte,
    output ow_busy, ow_presense, ow_out_byte
  );
endinterface

// File: rtl/ow_crc8.sv
// Registered Dallas/Maxim CRC-8 accumulator, one byte per enabled cycle.
module ow_crc8 import ow_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] crc
);

  logic [7:0] r_crc;
  logic [7:0] w_crc_nxt;

  assign w_crc_nxt = crc8_next(r_crc, din);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_crc <= 8'h00;
    else if (clr) r_crc <= 8'h00;
    else if (en)  r_crc <= w_crc_nxt;
  end

  assign crc = r_crc;

endmodule

// File: rtl/ds18b20_sequencer.sv
// Runs one DS18B20 conversion + scratchpad read per start request through the
// one_wire byte engine and publishes the raw temperature with error flags.
module ds18b20_sequencer import ow_pkg::*; #(
  parameter int CLK_MHZ      = 24,
  parameter int CONV_WAIT_MS = 750,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic [15:0]         temp,
  output logic                temp_valid,
  output logic                err_presence,
  output logic                err_crc,
  output logic                err_timeout,
  ds18b20_sequencer_if.master ow
);

  localparam int US_W  = $clog2(CLK_MHZ + 1);
  localparam int MS_W  = $clog2(CONV_WAIT_MS + 1);
  localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);
  localparam int SH_W  = 8 * SCRATCH_BYTES;

  localparam logic [US_W-1:0]  US_LAST  = US_W'(CLK_MHZ - 1);
  localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(CONV_WAIT_MS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);
  localparam logic [9:0]       MSIN_LAST = 10'd999;
  localparam logic [3:0]       IDX_LAST  = 4'(SCRATCH_BYTES - 1);

  function automatic logic is_cmd(input seq_state_t s);
    return (s == ST_RST1) || (s == ST_SKIP1) || (s == ST_CONV) || (s == ST_RST2) ||
           (s == ST_SKIP2) || (s == ST_RDCMD) || (s == ST_RDBYTE);
  endfunction

  function automatic logic [7:0] cmd_byte(input seq_state_t s);
    case (s)
      ST_SKIP1, ST_SKIP2: return OW_CMD_SKIP_ROM;
      ST_CONV:            return OW_CMD_CONVERT_T;
      ST_RDCMD:           return OW_CMD_READ_SCRATCH;
      default:            return 8'h00;
    endcase
  endfunction

  seq_state_t       r_state, w_state_nxt;
  cmd_phase_t       r_phase, w_phase_nxt;
  logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
  logic [US_W-1:0]  r_us, w_us_nxt;
  logic [9:0]       r_msin, w_msin_nxt;
  logic [MS_W-1:0]  r_ms, w_ms_nxt;
  logic [3:0]       r_idx, w_idx_nxt;
  logic [SH_W-1:0]  r_shadow;
  logic [7:0]       r_in_byte;
  logic             r_busy, w_busy_nxt;
  logic [15:0]      r_temp, w_temp_nxt;
  logic             r_temp_valid, w_tv_nxt;
  logic             r_err_p, w_err_p_nxt;
  logic             r_err_c, w_err_c_nxt;
  logic             r_err_t, w_err_t_nxt;
  logic             w_issue, w_done, w_cap, w_crc_clr, w_crc_en;
  logic [7:0]       w_crc;

  ow_crc8 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_crc_clr),
    .en    (w_crc_en),
    .din   (ow.ow_out_byte),
    .crc   (w_crc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_tmo_nxt   = r_tmo;
    w_us_nxt    = r_us;
    w_msin_nxt  = r_msin;
    w_ms_nxt    = r_ms;
    w_idx_nxt   = r_idx;
    w_busy_nxt  = r_busy;
    w_temp_nxt  = r_temp;
    w_tv_nxt    = 1'b0;
    w_err_p_nxt = r_err_p;
    w_err_c_nxt = r_err_c;
    w_err_t_nxt = r_err_t;
    w_issue     = 1'b0;
    w_done      = 1'b0;
    w_cap       = 1'b0;
    w_crc_clr   = 1'b0;
    w_crc_en    = 1'b0;

    // Shared handshake; the ISSUE cycle itself counts toward the busy timeout.
    if (is_cmd(r_state)) begin
      unique case (r_phase)
        PH_ISSUE: if (!ow.ow_busy) begin
          w_issue     = 1'b1;
          w_phase_nxt = PH_WHI;
          w_tmo_nxt   = TMO_W'(1);
        end
        PH_WHI: begin
          if (ow.ow_busy) begin
            w_phase_nxt = PH_WLO;
          end else if (r_tmo >= TMO_LAST) begin
            w_err_t_nxt = 1'b1;
            w_phase_nxt = PH_ISSUE;
            w_state_nxt = ST_ERROR;
          end else begin
            w_tmo_nxt = r_tmo + TMO_W'(1);
          end
        end
        PH_WLO: if (!ow.ow_busy) begin
          w_done      = 1'b1;
          w_phase_nxt = PH_ISSUE;
        end
        default: w_phase_nxt = PH_ISSUE;
      endcase
    end

    unique case (r_state)
      ST_IDLE: if (start) begin
        w_err_p_nxt = 1'b0;
        w_err_c_nxt = 1'b0;
        w_err_t_nxt = 1'b0;
        w_busy_nxt  = 1'b1;
        w_crc_clr   = 1'b1;
        w_phase_nxt = PH_ISSUE;
        w_state_nxt = ST_RST1;
      end
      ST_RST1, ST_RST2: if (w_done) begin
        if (!ow.ow_presense) begin
          w_err_p_nxt = 1'b1;
          w_state_nxt = ST_ERROR;
        end else begin
          w_state_nxt = (r_state == ST_RST1) ? ST_SKIP1 : ST_SKIP2;
        end
      end
      ST_SKIP1: if (w_done) w_state_nxt = ST_CONV;
      ST_CONV: if (w_done) begin
        w_us_nxt    = '0;
        w_msin_nxt  = '0;
        w_ms_nxt    = '0;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_us == US_LAST) begin
          w_us_nxt = '0;
          if (r_msin == MSIN_LAST) begin
            w_msin_nxt = '0;
            if (r_ms == MS_LAST) w_state_nxt = ST_RST2;
            else                 w_ms_nxt    = r_ms + MS_W'(1);
          end else begin
            w_msin_nxt = r_msin + 10'd1;
          end
        end else begin
          w_us_nxt = r_us + US_W'(1);
        end
      end
      ST_SKIP2: if (w_done) w_state_nxt = ST_RDCMD;
      ST_RDCMD: if (w_done) begin
        w_idx_nxt   = '0;
        w_state_nxt = ST_RDBYTE;
      end
      ST_RDBYTE: if (w_done) begin
        w_cap    = 1'b1;
        w_crc_en = 1'b1;
        if (r_idx == IDX_LAST) w_state_nxt = ST_CHECK;
        else                   w_idx_nxt   = r_idx + 4'd1;
      end
      // An all-zero scratchpad has a zero residue too; that is a stuck-low bus.
      ST_CHECK: begin
        if ((w_crc == 8'h00) && (|r_shadow)) begin
          w_temp_nxt  = r_shadow[15:0];
          w_tv_nxt    = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_err_c_nxt = 1'b1;
          w_state_nxt = ST_ERROR;
        end
      end
      ST_ERROR: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_phase      <= PH_ISSUE;
      r_tmo        <= '0;
      r_us         <= '0;
      r_msin       <= '0;
      r_ms         <= '0;
      r_idx        <= '0;
      r_shadow     <= '0;
      r_in_byte    <= 8'h00;
      r_busy       <= 1'b0;
      r_temp       <= 16'h0000;
      r_temp_valid <= 1'b0;
      r_err_p      <= 1'b0;
      r_err_c      <= 1'b0;
      r_err_t      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_phase      <= w_phase_nxt;
      r_tmo        <= w_tmo_nxt;
      r_us         <= w_us_nxt;
      r_msin       <= w_msin_nxt;
      r_ms         <= w_ms_nxt;
      r_idx        <= w_idx_nxt;
      r_in_byte    <= cmd_byte(w_state_nxt);
      r_busy       <= w_busy_nxt;
      r_temp       <= w_temp_nxt;
      r_temp_valid <= w_tv_nxt;
      r_err_p      <= w_err_p_nxt;
      r_err_c      <= w_err_c_nxt;
      r_err_t      <= w_err_t_nxt;
      if (w_cap) r_shadow[{r_idx, 3'b000} +: 8] <= ow.ow_out_byte;
    end
  end

  assign ow.ow_reset      = w_issue && ((r_state == ST_RST1) || (r_state == ST_RST2));
  assign ow.ow_write_byte = w_issue && ((r_state == ST_SKIP1) || (r_state == ST_CONV) ||
                                        (r_state == ST_SKIP2) || (r_state == ST_RDCMD));
  assign ow.ow_read_byte  = w_issue && (r_state == ST_RDBYTE);
  assign ow.ow_in_byte    = r_in_byte;

  assign busy         = r_busy;
  assign temp         = r_temp;
  assign temp_valid   = r_temp_valid;
  assign err_presence = r_err_p;
  assign err_crc      = r_err_c;
  assign err_timeout  = r_err_t;

endmodule
